uart_cmd_master: RTL and testbench

Host-side command initiator for the multi-clock register/ALU system: it builds the command frames the system's controller decodes, streams them byte-by-byte into a UART transmitter, collects the response bytes from a UART receiver, and returns one assembled response per command. It is the requesting end of the same byte protocol the system answers. It is used as the bench/host driver and as the embedded master on the host FPGA side.

---
 rtl/uart_cmd_master_if.sv | 48 ++++
 rtl/uart_cmd_master.sv | 167 ++++++++++++++++
 tb/tb_uart_cmd_master.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_master_if.sv
// ---------------------------------------------------------------------------
// uart_cmd_master_if
//   Signal bundle between the command initiator and its surroundings: the
//   command request port, the byte stream toward a UART transmitter, the byte
//   strobe from a UART receiver, and the assembled response.
//
//   Handshake rules for every valid/ready pair in this bundle:
//     A transfer happens in a cycle where valid && ready are both high at the
//     rising clock edge. Once valid is raised, the source holds valid and its
//     data stable until that transfer. The sink may raise or drop ready freely.
//     RX_VALID, RSP_VALID and RSP_TIMEOUT are one-cycle strobes with no ready.
//
//   Modports:
//     master - the command initiator (drives CMD_READY, TX_*, RSP_*, BUSY)
//     slave  - the host/UART side (drives CMD_*, TX_READY, RX_*)
// ---------------------------------------------------------------------------
interface uart_cmd_master_if #(
  parameter int DATA_WIDTH = 8
);
  logic                    CMD_VALID;
  logic                    CMD_READY;
  logic [1:0]              CMD_TYPE;
  logic [DATA_WIDTH-1:0]   CMD_ADDR;
  logic [DATA_WIDTH-1:0]   CMD_OP_A;
  logic [DATA_WIDTH-1:0]   CMD_OP_B;
  logic [DATA_WIDTH-1:0]   CMD_FUNC;
  logic [DATA_WIDTH-1:0]   TX_DATA;
  logic                    TX_VALID;
  logic                    TX_READY;
  logic [DATA_WIDTH-1:0]   RX_DATA;
  logic                    RX_VALID;
  logic [2*DATA_WIDTH-1:0] RSP_DATA;
  logic                    RSP_VALID;
  logic                    RSP_TIMEOUT;
  logic                    BUSY;

  modport master (
    input  CMD_VALID, CMD_TYPE, CMD_ADDR, CMD_OP_A, CMD_OP_B, CMD_FUNC,
    input  TX_READY, RX_DATA, RX_VALID,
    output CMD_READY, TX_DATA, TX_VALID, RSP_DATA, RSP_VALID, RSP_TIMEOUT, BUSY
  );

  modport slave (
    output CMD_VALID, CMD_TYPE, CMD_ADDR, CMD_OP_A, CMD_OP_B, CMD_FUNC,
    output TX_READY, RX_DATA, RX_VALID,
    input  CMD_READY, TX_DATA, TX_VALID, RSP_DATA, RSP_VALID, RSP_TIMEOUT, BUSY
  );
endinterface

// File: rtl/uart_cmd_master.sv
// ---------------------------------------------------------------------------
// uart_cmd_master
//   Host-side command initiator. Accepts one command, streams its frame bytes
//   to a UART TX, gathers 0/1/2 response bytes from a UART RX (LSB first),
//   and finishes with a one-cycle RSP_VALID, or RSP_TIMEOUT if the gap between
//   response bytes exceeds TIMEOUT cycles.
//
//   Ports:
//     CLK         - clock
//     RST         - asynchronous active-low reset
//     bus         - uart_cmd_master_if.master (command, TX, RX, response, BUSY)
//     o_dbg_state - current FSM state (0 IDLE, 1 SEND, 2 WAIT_RSP, 3 DONE, 4 ABORT)
//
//   Frames: 00 -> AA ADDR OP_A | 01 -> BB ADDR | 10 -> CC OP_A OP_B FUNC |
//           11 -> DD FUNC
// ---------------------------------------------------------------------------
module uart_cmd_master #(
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 4096,
  parameter int TO_W       = 13
) (
  input  logic                    CLK,
  input  logic                    RST,
  uart_cmd_master_if.master       bus,
  output logic [2:0]              o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEND  = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ABORT = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_next;

  logic [1:0]              r_type;
  logic [DATA_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_op_a;
  logic [DATA_WIDTH-1:0]   r_op_b;
  logic [DATA_WIDTH-1:0]   r_func;
  logic [1:0]              r_idx;
  logic [2:0]              r_len;
  logic [1:0]              r_rsp_cnt;
  logic [1:0]              r_rx_cnt;
  logic [TO_W-1:0]         r_to_cnt;
  logic [2*DATA_WIDTH-1:0] r_rsp_data;

  logic                    w_accept;
  logic                    w_tx_fire;
  logic                    w_last_byte;
  logic                    w_rx_fire;
  logic                    w_rx_last;
  logic                    w_to_expire;
  logic [DATA_WIDTH-1:0]   w_frame_byte;

  assign w_accept    = bus.CMD_VALID && (r_state == S_IDLE);
  assign w_tx_fire   = (r_state == S_SEND) && bus.TX_READY;
  assign w_last_byte = ({1'b0, r_idx} == (r_len - 3'd1));
  assign w_rx_fire   = (r_state == S_WAIT) && bus.RX_VALID;
  assign w_rx_last   = (r_rx_cnt == (r_rsp_cnt - 2'd1));
  assign w_to_expire = (r_to_cnt == TO_W'(TIMEOUT - 1));

  // Frame byte selected by command type and byte index.
  always_comb begin
    w_frame_byte = '0;
    case (r_type)
      2'b00: case (r_idx)
               2'd0:    w_frame_byte = DATA_WIDTH'(8'hAA);
               2'd1:    w_frame_byte = r_addr;
               default: w_frame_byte = r_op_a;
             endcase
      2'b01: w_frame_byte = (r_idx == 2'd0) ? DATA_WIDTH'(8'hBB) : r_addr;
      2'b10: case (r_idx)
               2'd0:    w_frame_byte = DATA_WIDTH'(8'hCC);
               2'd1:    w_frame_byte = r_op_a;
               2'd2:    w_frame_byte = r_op_b;
               default: w_frame_byte = r_func;
             endcase
      default: w_frame_byte = (r_idx == 2'd0) ? DATA_WIDTH'(8'hDD) : r_func;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic. A byte arriving in the same cycle as timeout expiry wins.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_SEND;
      S_SEND:  if (w_tx_fire && w_last_byte)
                 w_next = (r_rsp_cnt == 2'd0) ? S_DONE : S_WAIT;
      S_WAIT:  if (w_rx_fire) begin
                 if (w_rx_last) w_next = S_DONE;
               end else if (w_to_expire) begin
                 w_next = S_ABORT;
               end
      S_DONE:  w_next = S_IDLE;
      S_ABORT: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state, so reset forces them immediately.
  always_comb begin
    bus.CMD_READY   = (r_state == S_IDLE);
    bus.TX_VALID    = (r_state == S_SEND);
    bus.TX_DATA     = (r_state == S_SEND) ? w_frame_byte : '0;
    bus.RSP_VALID   = (r_state == S_DONE);
    bus.RSP_TIMEOUT = (r_state == S_ABORT);
    bus.BUSY        = (r_state != S_IDLE);
    bus.RSP_DATA    = r_rsp_data;
    o_dbg_state     = r_state;
  end

  // Command capture, byte index, response assembly and timeout counter.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_type     <= '0;
      r_addr     <= '0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_func     <= '0;
      r_idx      <= '0;
      r_len      <= '0;
      r_rsp_cnt  <= '0;
      r_rx_cnt   <= '0;
      r_to_cnt   <= '0;
      r_rsp_data <= '0;
    end else if (w_accept) begin
      r_type     <= bus.CMD_TYPE;
      r_addr     <= bus.CMD_ADDR;
      r_op_a     <= bus.CMD_OP_A;
      r_op_b     <= bus.CMD_OP_B;
      r_func     <= bus.CMD_FUNC;
      r_idx      <= '0;
      r_rx_cnt   <= '0;
      r_to_cnt   <= '0;
      r_rsp_data <= '0;
      case (bus.CMD_TYPE)
        2'b00:   begin r_len <= 3'd3; r_rsp_cnt <= 2'd0; end
        2'b01:   begin r_len <= 3'd2; r_rsp_cnt <= 2'd1; end
        2'b10:   begin r_len <= 3'd4; r_rsp_cnt <= 2'd2; end
        default: begin r_len <= 3'd2; r_rsp_cnt <= 2'd2; end
      endcase
    end else if (w_tx_fire) begin
      r_idx <= r_idx + 2'd1;
      if (w_last_byte) r_to_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      if (bus.RX_VALID) begin
        if (r_rx_cnt == 2'd0) r_rsp_data[DATA_WIDTH-1:0]            <= bus.RX_DATA;
        else                  r_rsp_data[2*DATA_WIDTH-1:DATA_WIDTH] <= bus.RX_DATA;
        r_rx_cnt <= r_rx_cnt + 2'd1;
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_master.sv
module tb_uart_cmd_master;
  localparam int DW      = 8;
  localparam int TIMEOUT = 4096;
  localparam int TO_W    = 13;

  logic       CLK = 1'b0;
  logic       RST;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected TX bytes and expected responses {is_timeout, data}.
  logic [DW-1:0]   exp_q[$];
  logic [2*DW:0]   rsp_q[$];

  uart_cmd_master_if #(.DATA_WIDTH(DW)) bus ();

  uart_cmd_master #(.DATA_WIDTH(DW), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  task automatic apply_reset();
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;

  always @(negedge CLK) begin
    logic [DW-1:0] e;
    logic [2*DW:0] er;
    logic [2*DW:0] obs;
    if (!RST) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (bus.TX_VALID !== 1'b1 || bus.TX_DATA !== prev_data) begin
          errors++;
          $display("FAIL tx_hold: valid=%0b data=%h, required valid=1 data=%h",
                   bus.TX_VALID, bus.TX_DATA, prev_data);
        end
      end
      if (bus.TX_VALID === 1'b1 && bus.TX_READY === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tx_extra: byte %h transferred, required none", bus.TX_DATA);
        end else begin
          e = exp_q.pop_front();
          if (bus.TX_DATA !== e) begin
            errors++;
            $display("FAIL tx_byte: got %h, required %h", bus.TX_DATA, e);
          end
        end
      end
      if (bus.RSP_VALID === 1'b1 || bus.RSP_TIMEOUT === 1'b1) begin
        checks++;
        obs = {bus.RSP_TIMEOUT, bus.RSP_DATA};
        if (rsp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_extra: valid=%0b timeout=%0b data=%h, required no pulse",
                   bus.RSP_VALID, bus.RSP_TIMEOUT, bus.RSP_DATA);
        end else begin
          er = rsp_q.pop_front();
          if (obs !== er || (bus.RSP_VALID === 1'b1 && bus.RSP_TIMEOUT === 1'b1)) begin
            errors++;
            $display("FAIL rsp: valid=%0b timeout=%0b data=%h, required timeout=%0b data=%h",
                     bus.RSP_VALID, bus.RSP_TIMEOUT, bus.RSP_DATA, er[2*DW], er[2*DW-1:0]);
          end
        end
      end
      prev_stall = (bus.TX_VALID === 1'b1) && (bus.TX_READY !== 1'b1);
      prev_data  = bus.TX_DATA;
    end
  end

  // ---------------- drivers ----------------
  task automatic send_cmd(input logic [1:0] t, input logic [DW-1:0] addr,
                          input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] f);
    int guard = 0;
    @(posedge CLK); #1;
    while (bus.CMD_READY !== 1'b1 && guard < 100) begin
      @(posedge CLK); #1;
      guard++;
    end
    checks++;
    if (bus.CMD_READY !== 1'b1) begin
      errors++;
      $display("FAIL cmd_ready_wait: CMD_READY=%0b, required 1", bus.CMD_READY);
    end
    case (t)
      2'b00:   begin exp_q.push_back(8'hAA); exp_q.push_back(addr); exp_q.push_back(a); end
      2'b01:   begin exp_q.push_back(8'hBB); exp_q.push_back(addr); end
      2'b10:   begin exp_q.push_back(8'hCC); exp_q.push_back(a); exp_q.push_back(b);
                     exp_q.push_back(f); end
      default: begin exp_q.push_back(8'hDD); exp_q.push_back(f); end
    endcase
    bus.CMD_TYPE  = t;
    bus.CMD_ADDR  = addr;
    bus.CMD_OP_A  = a;
    bus.CMD_OP_B  = b;
    bus.CMD_FUNC  = f;
    bus.CMD_VALID = 1'b1;
    @(posedge CLK); #1;
    bus.CMD_VALID = 1'b0;
    // Scramble fields: the DUT must use the values captured at acceptance.
    bus.CMD_TYPE  = 2'($urandom_range(0, 3));
    bus.CMD_ADDR  = DW'($urandom_range(0, 255));
    bus.CMD_OP_A  = DW'($urandom_range(0, 255));
    bus.CMD_OP_B  = DW'($urandom_range(0, 255));
    bus.CMD_FUNC  = DW'($urandom_range(0, 255));
  endtask

  task automatic rx_byte(input logic [DW-1:0] b);
    @(posedge CLK); #1;
    bus.RX_DATA  = b;
    bus.RX_VALID = 1'b1;
    @(posedge CLK); #1;
    bus.RX_VALID = 1'b0;
    bus.RX_DATA  = DW'($urandom_range(0, 255));
  endtask

  task automatic check_done(input string name);
    @(negedge CLK);
    checks++;
    if (bus.RSP_VALID !== 1'b1) begin
      errors++;
      $display("FAIL %s_rsp_cycle: RSP_VALID=%0b, required 1", name, bus.RSP_VALID);
    end
    @(negedge CLK);
    checks++;
    if (bus.CMD_READY !== 1'b1 || bus.RSP_VALID !== 1'b0) begin
      errors++;
      $display("FAIL %s_ready_after: CMD_READY=%0b RSP_VALID=%0b, required 1 0",
               name, bus.CMD_READY, bus.RSP_VALID);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge CLK);
    checks++;
    if (bus.CMD_READY !== 1'b1 || bus.TX_VALID !== 1'b0 || bus.TX_DATA !== 8'h00 ||
        bus.RSP_DATA !== 16'h0000 || bus.RSP_VALID !== 1'b0 || bus.RSP_TIMEOUT !== 1'b0 ||
        bus.BUSY !== 1'b0 || dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: rdy=%0b txv=%0b txd=%h rsp=%h rv=%0b rt=%0b busy=%0b st=%0d, required 1 0 00 0000 0 0 0 0",
               bus.CMD_READY, bus.TX_VALID, bus.TX_DATA, bus.RSP_DATA, bus.RSP_VALID,
               bus.RSP_TIMEOUT, bus.BUSY, dbg_state);
    end
  endtask

  task automatic test_write();
    bus.TX_READY = 1'b1;
    send_cmd(2'b00, 8'h02, 8'h81, 8'h00, 8'h00);
    rsp_q.push_back({1'b0, 16'h0000});
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if (bus.TX_VALID !== 1'b1 || bus.CMD_READY !== 1'b0 || bus.BUSY !== 1'b1) begin
        errors++;
        $display("FAIL write_send_cycle%0d: txv=%0b rdy=%0b busy=%0b, required 1 0 1",
                 i, bus.TX_VALID, bus.CMD_READY, bus.BUSY);
      end
    end
    check_done("write");
  endtask

  task automatic test_read();
    bus.TX_READY = 1'b1;
    send_cmd(2'b01, 8'h05, 8'h00, 8'h00, 8'h00);
    rsp_q.push_back({1'b0, 16'h003C});
    repeat (50) @(posedge CLK);
    rx_byte(8'h3C);
    check_done("read");
  endtask

  task automatic test_alu();
    bus.TX_READY = 1'b1;
    send_cmd(2'b10, 8'h00, 8'h10, 8'h20, 8'h02);
    rsp_q.push_back({1'b0, 16'h0200});
    @(negedge CLK);
    checks++;
    if (bus.RSP_DATA !== 16'h0000 || bus.TX_DATA !== 8'hCC) begin
      errors++;
      $display("FAIL alu_accept: RSP_DATA=%h TX_DATA=%h, required 0000 cc", bus.RSP_DATA, bus.TX_DATA);
    end
    repeat (10) @(posedge CLK);
    rx_byte(8'h00);
    repeat (5) @(posedge CLK);
    rx_byte(8'h02);
    check_done("alu");
  endtask

  task automatic test_backpressure();
    int g = 0;
    bus.TX_READY = 1'b0;
    send_cmd(2'b11, 8'h00, 8'h00, 8'h00, 8'h05);
    rsp_q.push_back({1'b0, 16'h1234});
    while (exp_q.size() > 0 && g < 300) begin
      @(posedge CLK); #1;
      bus.TX_READY = 1'($urandom_range(0, 1));
      g++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_drain: %0d bytes left, required 0", exp_q.size());
    end
    bus.TX_READY = 1'b1;
    repeat (3) @(posedge CLK);
    rx_byte(8'h34);
    rx_byte(8'h12);
    check_done("bp");
  endtask

  task automatic test_timeout();
    int hit = -1;
    bus.TX_READY = 1'b1;
    send_cmd(2'b10, 8'h00, 8'h11, 8'h22, 8'h33);
    rsp_q.push_back({1'b1, 16'h007F});
    repeat (8) @(posedge CLK);
    rx_byte(8'h7F);
    for (int k = 1; k <= TIMEOUT + 1; k++) begin
      @(negedge CLK);
      if (bus.RSP_TIMEOUT === 1'b1 && hit < 0) hit = k;
    end
    checks++;
    if (hit != TIMEOUT + 1) begin
      errors++;
      $display("FAIL timeout_cycle: pulse %0d cycles after byte, required %0d", hit, TIMEOUT + 1);
    end
    @(negedge CLK);
    checks++;
    if (bus.CMD_READY !== 1'b1 || bus.RSP_DATA !== 16'h007F) begin
      errors++;
      $display("FAIL timeout_after: CMD_READY=%0b RSP_DATA=%h, required 1 007f",
               bus.CMD_READY, bus.RSP_DATA);
    end
  endtask

  task automatic test_reset_mid();
    repeat (2) @(posedge CLK);
    rx_byte(8'h99);
    @(negedge CLK);
    checks++;
    if (dbg_state !== 3'd0 || bus.RSP_DATA !== 16'h007F || bus.CMD_READY !== 1'b1) begin
      errors++;
      $display("FAIL stray_rx: state=%0d RSP_DATA=%h rdy=%0b, required 0 007f 1",
               dbg_state, bus.RSP_DATA, bus.CMD_READY);
    end
    bus.TX_READY = 1'b0;
    send_cmd(2'b00, 8'h01, 8'h02, 8'h03, 8'h04);
    @(negedge CLK);
    checks++;
    if (bus.TX_VALID !== 1'b1 || dbg_state !== 3'd1) begin
      errors++;
      $display("FAIL mid_send: txv=%0b state=%0d, required 1 1", bus.TX_VALID, dbg_state);
    end
    #2 RST = 1'b0;
    #1;
    checks++;
    if (bus.CMD_READY !== 1'b1 || bus.TX_VALID !== 1'b0 || bus.TX_DATA !== 8'h00 ||
        bus.RSP_DATA !== 16'h0000 || bus.RSP_VALID !== 1'b0 || bus.RSP_TIMEOUT !== 1'b0 ||
        bus.BUSY !== 1'b0 || dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL async_reset: rdy=%0b txv=%0b txd=%h rsp=%h rv=%0b rt=%0b busy=%0b st=%0d, required 1 0 00 0000 0 0 0 0",
               bus.CMD_READY, bus.TX_VALID, bus.TX_DATA, bus.RSP_DATA, bus.RSP_VALID,
               bus.RSP_TIMEOUT, bus.BUSY, dbg_state);
    end
    exp_q.delete();
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    bus.TX_READY = 1'b1;
    repeat (20) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (dbg_state !== 3'd0 || bus.CMD_READY !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_idle: state=%0d rdy=%0b, required 0 1", dbg_state, bus.CMD_READY);
    end
  endtask

  // ---------------- main ----------------
  initial begin
    bus.CMD_VALID = 1'b0;
    bus.CMD_TYPE  = '0;
    bus.CMD_ADDR  = '0;
    bus.CMD_OP_A  = '0;
    bus.CMD_OP_B  = '0;
    bus.CMD_FUNC  = '0;
    bus.TX_READY  = 1'b0;
    bus.RX_DATA   = '0;
    bus.RX_VALID  = 1'b0;
    apply_reset();
    test_reset();
    test_write();
    test_read();
    test_alu();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0 || rsp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left: tx=%0d rsp=%0d entries, required 0 0", exp_q.size(), rsp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
